// File: rtl/pipe_pkg.sv
// Shared defaults for pipeline stage registers: payload widths, counter width,
// the NOP encoding and the per-edge operation chosen by the stage.
package pipe_pkg;

    localparam int PIPE_PC_W    = 32;
    localparam int PIPE_INSTR_W = 32;
    localparam int PIPE_CNT_W   = 16;

    localparam logic [PIPE_INSTR_W-1:0] PIPE_NOP_INSTR = '0;

    // Resolved priority of the control inputs for the coming edge.
    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_HOLD  = 2'd1,
        OP_FLUSH = 2'd2
    } stage_op_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid store that catches an entry accepted while the main
// stage register is stalled downstream.
module pipe_skid_buf #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               unload,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               skid_valid,
    output logic [PC_W-1:0]    skid_pc,
    output logic [INSTR_W-1:0] skid_instr
);

    // Load wins over unload; the parent never asks for both on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (clear) begin
            skid_valid <= 1'b0;
        end else if (load) begin
            skid_valid <= 1'b1;
            skid_pc    <= load_pc;
            skid_instr <= load_instr;
        end else if (unload) begin
            skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, freeze, flush and a
// bubble counter. Define PIPE_STAGE_SKID_EN for the two-entry registered-ready build.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PIPE_PC_W,
    parameter int                 INSTR_W   = PIPE_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR),
    parameter int                 CNT_W     = PIPE_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   bubble_cnt
);

    stage_op_e          op;
    logic               run;
    logic               accept;
    logic               drain;
    logic               main_load;
    logic [PC_W-1:0]    main_pc_d;
    logic [INSTR_W-1:0] main_instr_d;

    always_comb begin
        op = OP_RUN;
        if (flush) begin
            op = OP_FLUSH;
        end else if (freeze) begin
            op = OP_HOLD;
        end
    end

    assign run    = (op == OP_RUN);
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready && run;

`ifdef PIPE_STAGE_SKID_EN
    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               skid_load;
    logic               skid_unload;

    // Ready comes only from the skid register, never from out_ready.
    assign in_ready    = !skid_valid && !freeze && !flush;
    assign skid_load   = accept && out_valid && !drain;
    assign skid_unload = drain && skid_valid;

    always_comb begin
        main_load    = 1'b0;
        main_pc_d    = in_pc;
        main_instr_d = in_instr;
        if (skid_valid) begin
            main_load    = drain;
            main_pc_d    = skid_pc;
            main_instr_d = skid_instr;
        end else begin
            main_load = accept && (!out_valid || drain);
        end
    end

    pipe_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .load       (skid_load),
        .unload     (skid_unload),
        .load_pc    (in_pc),
        .load_instr (in_instr),
        .skid_valid (skid_valid),
        .skid_pc    (skid_pc),
        .skid_instr (skid_instr)
    );
`else
    assign in_ready = (!out_valid || out_ready) && !freeze && !flush;

    always_comb begin
        main_load    = accept;
        main_pc_d    = in_pc;
        main_instr_d = in_instr;
    end
`endif

    // out_pc keeps its last value whenever the stage empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= NOP_INSTR;
        end else begin
            case (op)
                OP_FLUSH: begin
                    out_valid <= 1'b0;
                    out_instr <= NOP_INSTR;
                end
                OP_HOLD: begin
                    out_valid <= out_valid;
                end
                default: begin
                    if (main_load) begin
                        out_valid <= 1'b1;
                        out_pc    <= main_pc_d;
                        out_instr <= main_instr_d;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        out_instr <= NOP_INSTR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && !freeze && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

    localparam int          PC_W    = 32;
    localparam int          INSTR_W = 32;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          BUB_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP     = 2;
`else
    localparam int          CAP     = 1;
`endif

    logic               clk = 1'b0;
    logic               clk_en = 1'b0;
    logic               rst;
    logic               freeze;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [CNT_W-1:0]   bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      model_q[$];
    logic [31:0] model_pc;
    int          model_bub;
    bit          m_acc;
    int          m_pre;

    pipe_stage_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = clk_en ? ~clk : 1'b0;

    // The stage is a FIFO of capacity CAP; ready depends on occupancy.
    function automatic bit model_in_ready();
        if (freeze || flush) return 1'b0;
        if (CAP == 2) return model_q.size() < 2;
        return (model_q.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            model_pc  = '0;
            model_bub = 0;
        end else begin
            m_pre = model_q.size();
            m_acc = in_valid && model_in_ready();
            if (m_pre == 0 && out_ready && !freeze && model_bub < BUB_MAX) model_bub++;
            if (flush) begin
                model_q.delete();
            end else if (!freeze) begin
                if (m_pre > 0 && out_ready) void'(model_q.pop_front());
                if (m_acc) model_q.push_back('{pc: in_pc, instr: in_instr});
            end
            if (model_q.size() > 0) model_pc = model_q[0].pc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit exp_valid;
        exp_valid = model_q.size() > 0;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_instr", out_instr, exp_valid ? model_q[0].instr : NOP);
        check("out_pc", out_pc, model_pc);
        check("bubble_cnt", 32'(bubble_cnt), 32'(model_bub));
        check("in_ready", 32'(in_ready), 32'(model_in_ready()));
    endtask

    task automatic applyStimulus(input bit frz, input bit fl, input bit iv,
                                 input logic [31:0] pc, input logic [31:0] ins,
                                 input bit ordy);
        @(posedge clk);
        #1;
        freeze    = frz;
        flush     = fl;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instr = '0; out_ready = 1'b0;
        #2;
        check("rst0_valid", 32'(out_valid), 32'd0);
        check("rst0_pc", out_pc, 32'd0);
        check("rst0_instr", out_instr, NOP);
        check("rst0_bubble", 32'(bubble_cnt), 32'd0);
        #1;
        rst = 1'b0;
        clk_en = 1'b1;

        $display("[TB] stream");
        applyStimulus(0, 0, 1, 32'h0, 32'hE3A0_1001, 1);
        check("stream_c1_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 0, 1, 32'h4, 32'hE3A0_1002, 1);
        check("stream_c2_pc", out_pc, 32'h0);
        check("stream_c2_instr", out_instr, 32'hE3A0_1001);
        applyStimulus(0, 0, 1, 32'h8, 32'hE3A0_1003, 1);
        check("stream_c3_pc", out_pc, 32'h4);
        check("stream_c3_valid", 32'(out_valid), 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("stream_c4_pc", out_pc, 32'h8);
        check("stream_c4_instr", out_instr, 32'hE3A0_1003);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("stream_c5_valid", 32'(out_valid), 32'd0);
        check("stream_c5_instr", out_instr, NOP);

        $display("[TB] freeze");
        applyStimulus(0, 0, 1, 32'h10, 32'hAAAA_0010, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 32'h14, 32'hAAAA_0014, 1);
            check("freeze_pc", out_pc, 32'h10);
            check("freeze_in_ready", 32'(in_ready), 32'd0);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("freeze_release_pc", out_pc, 32'h10);
        check("freeze_release_valid", 32'(out_valid), 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("freeze_single_consume", 32'(out_valid), 32'd0);

        $display("[TB] flush");
        applyStimulus(0, 0, 1, 32'h20, 32'hBBBB_0020, 0);
        applyStimulus(0, 1, 1, 32'h24, 32'hBBBB_0024, 0);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_pre_pc", out_pc, 32'h20);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_instr", out_instr, NOP);
        check("flush_pc_hold", out_pc, 32'h20);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("flush_dropped", out_pc, 32'h20);

        $display("[TB] backpressure");
        applyStimulus(0, 0, 1, 32'h30, 32'hCCCC_0030, 0);
        check("bp_ready_empty", 32'(in_ready), 32'd1);
        applyStimulus(0, 0, 1, 32'h34, 32'hCCCC_0034, 0);
        check("bp_ready_second", 32'(in_ready), (CAP == 2) ? 32'd1 : 32'd0);
        applyStimulus(0, 0, 1, 32'h38, 32'hCCCC_0038, 0);
        check("bp_ready_full", 32'(in_ready), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("bp_first_out", out_pc, 32'h30);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("bp_second_valid", 32'(out_valid), (CAP == 2) ? 32'd1 : 32'd0);
        check("bp_second_pc", out_pc, (CAP == 2) ? 32'h34 : 32'h30);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);

        $display("[TB] async reset with clock stopped");
        applyStimulus(0, 0, 1, 32'h50, 32'hDDDD_0050, 0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_stopped_valid", 32'(out_valid), 32'd0);
        check("rst_stopped_pc", out_pc, 32'd0);
        check("rst_stopped_instr", out_instr, NOP);
        check("rst_stopped_bubble", 32'(bubble_cnt), 32'd0);
        checkOutput();
        #1 rst = 1'b0;
        clk_en = 1'b1;

        $display("[TB] reset mid-transfer");
        applyStimulus(0, 0, 1, 32'h60, 32'hEEEE_0060, 0);
        applyStimulus(0, 0, 1, 32'h64, 32'hEEEE_0064, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        applyStimulus(0, 0, 1, 32'h70, 32'hEEEE_0070, 1);
        check("midrst_empty", 32'(out_valid), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("midrst_first_pc", out_pc, 32'h70);
        check("midrst_first_instr", out_instr, 32'hEEEE_0070);

        $display("[TB] bubble saturation");
        in_valid = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        check("bubble_saturate", 32'(bubble_cnt), 32'd15);

        $display("[TB] random traffic");
        in_valid = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                          $urandom, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC payload width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction payload width.
REQ-003 SHALL have parameter NOP_INSTR, default all-zero, instruction value driven when the stage holds no valid entry.
REQ-004 SHALL have parameter CNT_W, default 16, bubble counter width.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 freeze  input  1  hazard stall; hold stage contents.
REQ-008 flush  input  1  branch-taken kill; discard stage contents.
REQ-009 in_valid  input  1  upstream entry valid.
REQ-010 in_ready  output  1  stage accepts entry this cycle.
REQ-011 in_pc  input  PC_W  upstream PC.
REQ-012 in_instr  input  INSTR_W  upstream instruction.
REQ-013 out_valid  output  1  downstream entry valid.
REQ-014 out_ready  input  1  downstream accepts entry.
REQ-015 out_pc  output  PC_W  registered PC.
REQ-016 out_instr  output  INSTR_W  registered instruction, NOP_INSTR when out_valid=0.
REQ-017 bubble_cnt  output  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0.

Function
REQ-018 Upstream transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; downstream transfer with out_valid=1 and out_ready=1.
REQ-019 Latency SHALL be one cycle: an entry accepted at edge N appears on out_* after edge N when the stage was empty or draining.
REQ-020 Priority SHALL be rst > flush > freeze > normal handshake.
REQ-021 flush SHALL clear all held entries at the next edge: out_valid=0, out_instr=NOP_INSTR, out_pc holds its previous value; any in_valid entry offered in the flush cycle is dropped.
REQ-022 in_ready SHALL be 0 while freeze=1 or flush=1.
REQ-023 freeze SHALL hold out_valid, out_pc, out_instr and internal entries unchanged regardless of out_ready; downstream SHALL NOT consume while frozen.
REQ-024 Simultaneous accept and drain on one edge SHALL replace the entry without a bubble (full throughput, one entry per cycle).
REQ-025 Entries SHALL never be duplicated or reordered; order out equals order in.
REQ-026 bubble_cnt SHALL increment by 1 each cycle out_ready=1 and out_valid=0 and freeze=0, saturate at all-ones, never wrap.

Reset
REQ-027 On rst: out_valid=0, out_pc=0, out_instr=NOP_INSTR, bubble_cnt=0, all internal entries invalid, effective immediately and independent of clk.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; first accept after release SHALL be the first entry out.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: stage SHALL contain main plus skid entry; in_ready SHALL be a registered signal equal to (skid empty) and not freeze/flush, with no combinational path from out_ready to in_ready; an entry accepted while main is stalled goes to skid and moves to main on the next drain.
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: single entry; in_ready = (!out_valid || out_ready) && !freeze && !flush, combinational.
REQ-031 Both builds SHALL show identical transfer ordering, flush and freeze behaviour at the ports.

Structure
REQ-032 Package pipe_pkg SHALL hold default PC_W, INSTR_W, CNT_W and the NOP_INSTR encoding shared by all stage registers.
REQ-033 Skid storage SHALL be sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-034 rst pulse with clk stopped -> out_valid=0, out_pc=0, out_instr=NOP_INSTR, bubble_cnt=0 immediately.
REQ-035 Stream pc 0x0,0x4,0x8 with instr 0xE3A01001.. one per cycle, out_ready=1 -> same sequence on out_*, one cycle later, no gaps.
REQ-036 Entry pc 0x10 held, freeze=1 for 3 cycles with out_ready=1 -> out_pc stays 0x10, in_ready=0, single consume after freeze drops.
REQ-037 Stage holding pc 0x20, flush=1 with in_valid=1 pc 0x24 -> next cycle out_valid=0, out_instr=NOP_INSTR, 0x24 never appears.
REQ-038 out_ready=0 for 2 cycles with in_valid=1 (skid build) -> exactly two entries accepted, in_ready drops, both emerge in order after out_ready=1.
REQ-039 CNT_W=4, out_valid=0, out_ready=1 for 20 cycles -> bubble_cnt stops at 15.
